// File: rtl/sad_block_ctrl.sv
// sad_block_ctrl: row-wise SAD pipeline (|diff| -> 8:2 compressor tree -> accumulator)
// with block framing, a fixed two-cycle pipeline drain and a valid/ready result handoff.
module sad_block_ctrl #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LANES = 8,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned SAD_W = PIX_W + $clog2(LANES * ROWS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PIX_W-1:0]   cur_pix,
  input  logic [LANES*PIX_W-1:0]   ref_pix,
  output logic [SAD_W-1:0]         sad_out,
  output logic                     sad_valid,
  input  logic                     sad_ready,
  output logic                     busy
);

  localparam int unsigned RW    = PIX_W + 3;           // row-sum width for 8 lanes
  localparam int unsigned CNT_W = $clog2(ROWS + 1);    // beat counter, safe for ROWS=1

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic               drain_cnt;
  logic               accept;

  logic [PIX_W-1:0]   diff_c [LANES];
  logic [PIX_W-1:0]   s1_diff [LANES];
  logic               s1_valid;
  logic [RW-1:0]      row_sum_c;
  logic [RW-1:0]      s2_sum;
  logic               s2_valid;
  logic [SAD_W-1:0]   acc;

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign sad_valid = (state == DONE);
  assign sad_out   = acc;
  assign accept    = in_valid && in_ready;

  // Word-level 4:2 compressor: two carry-save stages, returns {carry, sum}.
  function automatic logic [2*RW-1:0] csa42(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                            input logic [RW-1:0] c, input logic [RW-1:0] d);
    logic [RW-1:0] s0, c0, s1, c1;
    s0 = a ^ b ^ c;
    c0 = ((a & b) | (a & c) | (b & c)) << 1;
    s1 = s0 ^ d ^ c0;
    c1 = ((s0 & d) | (s0 & c0) | (d & c0)) << 1;
    return {c1, s1};
  endfunction

  // Per-lane unsigned absolute difference.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      diff_c[i] = '0;
      if (cur_pix[i*PIX_W +: PIX_W] >= ref_pix[i*PIX_W +: PIX_W])
        diff_c[i] = cur_pix[i*PIX_W +: PIX_W] - ref_pix[i*PIX_W +: PIX_W];
      else
        diff_c[i] = ref_pix[i*PIX_W +: PIX_W] - cur_pix[i*PIX_W +: PIX_W];
    end
  end

  // 8:2 reduction of the S1 differences, then the final carry-propagate add.
  always_comb begin
    logic [RW-1:0]   ext [8];
    logic [2*RW-1:0] t0, t1, t2;
    for (int i = 0; i < 8; i++) ext[i] = RW'(s1_diff[i]);
    t0 = csa42(ext[0], ext[1], ext[2], ext[3]);
    t1 = csa42(ext[4], ext[5], ext[6], ext[7]);
    t2 = csa42(t0[RW-1:0], t0[2*RW-1:RW], t1[RW-1:0], t1[2*RW-1:RW]);
    row_sum_c = t2[RW-1:0] + t2[2*RW-1:RW];
  end

  // S1: capture lane differences of each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_diff[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept)
        for (int i = 0; i < LANES; i++) s1_diff[i] <= diff_c[i];
    end
  end

  // S2: capture the reduced row sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_sum <= row_sum_c;
    end
  end

  // Block accumulator: cleared on block start, adds each valid row sum.
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (state == IDLE && start)
      acc <= '0;
    else if (s2_valid)
      acc <= acc + SAD_W'(s2_sum);
  end

  // Block framing FSM: beat counting, fixed two-cycle drain, result handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            beat_cnt <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == CNT_W'(ROWS - 1)) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else           drain_cnt <= 1'b1;
        end
        DONE: begin
          if (sad_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
